ga23_vram_sched: RTL and testbench
==================================

# ga23_vram_sched

VRAM slot scheduler for the GA23 tilemap chip. It shares the single 16-bit VRAM port between three requesters: the three tile layers' fetches, the CPU's memory accesses, and the once-per-line rowscroll table fetch. Time is divided into a fixed 8-slot cycle advanced by the pixel enable. The block sits between the GA23 register/timing logic and the VRAM, and drives the layer load strobes and rowscroll values consumed by the layer engines.

## Interface

Parameters:
- RS_BASE, 15'h7800: VRAM word address of the rowscroll region. Layer k table base = RS_BASE + 'h200·(k+1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  pixel clock enable; all slot activity advances only on ce
- hpulse  in  1  line-start pulse, sampled on ce
- vcnt  in  10  current vertical count
- y_ofs0/1/2  in  10 each  layer vertical scroll
- layer_addr0/1/2  in  15 each  attribute-word VRAM address requested by layer k
- cpu_req  in  1  one-clk request pulse (any clk, not gated by ce)
- cpu_we  in  1  write qualifier, sampled with cpu_req
- cpu_addr  in  15  CPU word address, held stable while cpu_busy
- cpu_wdata  in  16  CPU write data, held stable while cpu_busy
- cpu_rdata  out  16  read result
- cpu_busy  out  1  high from the clk after cpu_req until the access completes
- vram_addr  out  15  VRAM word address
- vram_din  in  16  VRAM read data, valid one ce after vram_addr changes
- vram_dout  out  16  VRAM write data
- vram_we  out  1  write strobe, exactly one clk wide
- index_latch  out  16  tile index word latched for the layers
- layer_load  out  3  per-layer load strobe, one ce period wide
- rowscroll0/1/2  out  10 each  per-line rowscroll value
- rs_active  out  1  rowscroll fetch in progress

## Operation

- Slot counter `slot[2:0]`: increments by 1 mod 8 on each ce. On ce with hpulse, it loads 0 and sets `rs_pending`.
- Layer slots (only while rs_active = 0), with k = 0,1,2:
  - slot 2k: vram_addr ← layer_addrk.
  - slot 2k+1: vram_addr[0] ← 1; index_latch ← vram_din; layer_load[k] ← 1.
  - layer_load clears on the next ce.
- CPU FSM states are IDLE, PEND and ACC.
  - IDLE → PEND: on cpu_req; cpu_we is captured at the same time.
  - PEND → ACC: at slot 6 with rs_active = 0. vram_addr ← cpu_addr; vram_dout ← cpu_wdata; vram_we pulses for one clk if the access is a write.
  - ACC → IDLE: at slot 7. cpu_rdata ← vram_din (updated on writes too).
  - cpu_busy = (state ≠ IDLE).
  - cpu_req while busy is ignored.
  - cpu_req in the same clk as ACC → IDLE is ignored.
- Rowscroll entry: at slot 7 with rs_pending, clear rs_pending, set rs_active, and set rs_cyc ← 0. An ACC completion in the same slot still completes first.
- Rowscroll fetch (4-bit rs_cyc, +1 per ce while rs_active):
  - 0: vram_addr ← RS_BASE
  - 4: vram_addr ← RS_BASE + 'h200 + (y_ofs0+vcnt)[8:0]
  - 7: rowscroll0 ← vram_din[9:0]
  - 8: vram_addr ← RS_BASE + 'h400 + (y_ofs1+vcnt)[8:0]
  - 10: rowscroll1 ← vram_din[9:0]
  - 12: vram_addr ← RS_BASE + 'h600 + (y_ofs2+vcnt)[8:0]
  - 14: rowscroll2 ← vram_din[9:0]
  - 15: rs_active ← 0
- During rowscroll the slot counter keeps counting, layer and CPU slots are suppressed, and a PEND request waits for the next slot 6 with rs_active = 0.
- y sums are 10-bit modulo; only bits [8:0] form the offset, so the address wraps within each 512-word table.
- hpulse during rs_active only re-arms rs_pending and resets slot; the fetch in progress runs to rs_cyc 15.

## Timing

- Reset (async, reset_n low): every output 0, CPU FSM IDLE, slot 0, rs_cyc 0, rs_pending 0. A pending CPU request is dropped.
- Release of reset is synchronous to clk.
- CPU latency, with no rowscroll interference: from cpu_req to cpu_busy low is at most 8 ce + 2 clk. Worst case with a rowscroll burst is 24 ce + 2 clk.
- Fixed ce-to-output timing:
  - vram_we asserts on the clk of the slot-6 ce and deasserts on the next clk.
  - layer_load[k] rises at slot 2k+1 and falls at slot 2k+2.
- Rowscroll outputs change only at rs_cyc 7, 10 and 14 and are held until the next line's fetch.
- ce low freezes all state except CPU FSM capture (IDLE→PEND) and the vram_we clear.

## Test plan

- Free-run with ce every clk, layer_addr0 = 'h0120, vram_din = 'hABCD at slot 1 → vram_addr = 'h0120 at slot 0 and 'h0121 at slot 1; index_latch = 'hABCD; layer_load = 3'b001 for exactly one ce.
- cpu_req write, addr 'h1234, data 'h5A5A, issued at slot 2 → one vram_we clk with vram_addr 'h1234 and vram_dout 'h5A5A at slot 6; cpu_busy falls after slot 7.
- CPU read, addr 'h0040, with vram_din = 'h00FF → cpu_rdata = 'h00FF; a second cpu_req while busy causes no extra access.
- hpulse with vcnt = 10, y_ofs1 = 'h3FF, VRAM model returning 'h1C5 at 'h7C09 → rowscroll1 = 'h1C5; vram_addr for layer 1 is 'h7C09, showing the wrap; no layer_load pulses during rs_active; rs_active lasts 16 ce.
- CPU request pending at rowscroll entry → the access is deferred to the first slot 6 after rs_active falls, with data intact.
- reset_n pulsed low mid-access (state ACC) and mid-rowscroll → all outputs 0 immediately; after release, slot 0 and no stray vram_we.

Source files
------------

// File: rtl/ga23_vram_sched_if.sv
// CPU access port and VRAM port of the GA23 VRAM slot scheduler.
//
// CPU handshake: cpu_req is a single-clk request; it is accepted only when
// cpu_busy is low, and cpu_busy then stays high until the access has
// completed. The requester holds cpu_addr and cpu_wdata stable while
// cpu_busy is high. cpu_rdata is valid from the clk cpu_busy falls.
// VRAM side: vram_din is valid one ce after vram_addr changes. vram_we is
// a single-clk strobe.
interface ga23_vram_sched_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_busy;
  logic [14:0] vram_addr;
  logic [15:0] vram_din;
  logic [15:0] vram_dout;
  logic        vram_we;

  // Requester / memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_din,
    input  cpu_rdata, cpu_busy, vram_addr, vram_dout, vram_we
  );

  // Scheduler side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_din,
    output cpu_rdata, cpu_busy, vram_addr, vram_dout, vram_we
  );
endinterface

// File: rtl/ga23_vram_sched.sv
// GA23 VRAM slot scheduler: shares the single VRAM port between the three
// tile-layer fetches, CPU accesses and the per-line rowscroll table fetch
// using a fixed 8-slot cycle advanced by the pixel enable.
module ga23_vram_sched #(
  parameter logic [14:0] RS_BASE = 15'h7800
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        hpulse,
  input  logic [9:0]  vcnt,
  input  logic [9:0]  y_ofs0,
  input  logic [9:0]  y_ofs1,
  input  logic [9:0]  y_ofs2,
  input  logic [14:0] layer_addr0,
  input  logic [14:0] layer_addr1,
  input  logic [14:0] layer_addr2,
  ga23_vram_sched_if.slave bus,
  output logic [15:0] index_latch,
  output logic [2:0]  layer_load,
  output logic [9:0]  rowscroll0,
  output logic [9:0]  rowscroll1,
  output logic [9:0]  rowscroll2,
  output logic        rs_active,
  output logic [1:0]  cpu_state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;

  logic [2:0]  slot;
  logic        rs_pending;
  logic [3:0]  rs_cyc;
  logic [1:0]  cpu_state;
  logic        cpu_we_q;

  logic [9:0]  ysum0, ysum1, ysum2;
  logic [14:0] rs_addr;
  logic [14:0] lay_addr;
  logic        layer_slot;
  logic        cpu_start;
  logic        cpu_done;
  logic        rs_enter;

  // Per-layer line numbers; only the low 9 bits index the 512-word table.
  assign ysum0 = y_ofs0 + vcnt;
  assign ysum1 = y_ofs1 + vcnt;
  assign ysum2 = y_ofs2 + vcnt;

  assign layer_slot = ce && !rs_active && (slot[2:1] != 2'b11);
  assign cpu_start  = ce && !rs_active && (slot == 3'd6) && (cpu_state == S_PEND);
  assign cpu_done   = ce && (slot == 3'd7) && (cpu_state == S_ACC);
  assign rs_enter   = ce && !rs_active && (slot == 3'd7) && rs_pending;

  assign bus.cpu_busy  = (cpu_state != S_IDLE);
  assign cpu_state_dbg = cpu_state;

  // Rowscroll table address for the current fetch cycle (cycle 0 is a dummy)
  always_comb begin
    case (rs_cyc)
      4'd4:    rs_addr = RS_BASE + 15'h200 + {5'd0, ysum0 & 10'h1FF};
      4'd8:    rs_addr = RS_BASE + 15'h400 + {5'd0, ysum1 & 10'h1FF};
      4'd12:   rs_addr = RS_BASE + 15'h600 + {5'd0, ysum2 & 10'h1FF};
      default: rs_addr = RS_BASE;
    endcase
  end

  // Attribute address of the layer owning the current slot pair
  always_comb begin
    case (slot[2:1])
      2'd0:    lay_addr = layer_addr0;
      2'd1:    lay_addr = layer_addr1;
      default: lay_addr = layer_addr2;
    endcase
  end

  // Slot counter, line-start arming and rowscroll burst sequencing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot       <= 3'd0;
      rs_pending <= 1'b0;
      rs_active  <= 1'b0;
      rs_cyc     <= 4'd0;
    end else if (ce) begin
      slot <= hpulse ? 3'd0 : slot + 3'd1;
      // A new line start re-arms even in the slot that consumes the old one
      if (hpulse)        rs_pending <= 1'b1;
      else if (rs_enter) rs_pending <= 1'b0;
      if (rs_enter) begin
        rs_active <= 1'b1;
        rs_cyc    <= 4'd0;
      end else if (rs_active) begin
        rs_cyc <= rs_cyc + 4'd1;
        if (rs_cyc == 4'd15) rs_active <= 1'b0;
      end
    end
  end

  // CPU access FSM; request capture runs on every clk, not just on ce
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_state <= S_IDLE;
      cpu_we_q  <= 1'b0;
    end else begin
      case (cpu_state)
        S_IDLE: if (bus.cpu_req) begin
          cpu_state <= S_PEND;
          cpu_we_q  <= bus.cpu_we;
        end
        S_PEND: if (cpu_start) cpu_state <= S_ACC;
        S_ACC:  if (cpu_done)  cpu_state <= S_IDLE;
        default: cpu_state <= S_IDLE;
      endcase
    end
  end

  // VRAM address/data/strobe; the three owners never overlap in one ce
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.vram_addr <= 15'd0;
      bus.vram_dout <= 16'd0;
      bus.vram_we   <= 1'b0;
    end else begin
      bus.vram_we <= cpu_start && cpu_we_q;
      if (ce) begin
        if (rs_active) begin
          if (rs_cyc[1:0] == 2'd0) bus.vram_addr <= rs_addr;
        end else if (layer_slot) begin
          if (!slot[0]) bus.vram_addr    <= lay_addr;
          else          bus.vram_addr[0] <= 1'b1;
        end else if (cpu_start) begin
          bus.vram_addr <= bus.cpu_addr;
          bus.vram_dout <= bus.cpu_wdata;
        end
      end
    end
  end

  // Read-data captures: tile index, layer strobes, rowscroll values, CPU data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index_latch   <= 16'd0;
      layer_load    <= 3'd0;
      rowscroll0    <= 10'd0;
      rowscroll1    <= 10'd0;
      rowscroll2    <= 10'd0;
      bus.cpu_rdata <= 16'd0;
    end else begin
      if (ce) begin
        layer_load <= 3'd0;
        if (layer_slot && slot[0]) begin
          index_latch <= bus.vram_din;
          layer_load  <= 3'b001 << slot[2:1];
        end
        if (rs_active) begin
          case (rs_cyc)
            4'd7:    rowscroll0 <= bus.vram_din[9:0];
            4'd10:   rowscroll1 <= bus.vram_din[9:0];
            4'd14:   rowscroll2 <= bus.vram_din[9:0];
            default: ;
          endcase
        end
      end
      if (cpu_done) bus.cpu_rdata <= bus.vram_din;
    end
  end

endmodule

// File: tb/tb_ga23_vram_sched.sv
// Testbench for ga23_vram_sched: directed scenarios followed by randomized
// traffic, checked against a slot-level behavioural model and a CPU
// transaction scoreboard.
module tb_ga23_vram_sched;

  localparam int RS_BASE = 'h7800;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        ce, hpulse;
  logic [9:0]  vcnt, y_ofs0, y_ofs1, y_ofs2;
  logic [14:0] layer_addr0, layer_addr1, layer_addr2;
  logic [15:0] index_latch;
  logic [2:0]  layer_load;
  logic [9:0]  rowscroll0, rowscroll1, rowscroll2;
  logic        rs_active;
  logic [1:0]  cpu_state_dbg;

  ga23_vram_sched_if bus_if();

  ga23_vram_sched #(.RS_BASE(15'h7800)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .hpulse(hpulse), .vcnt(vcnt),
    .y_ofs0(y_ofs0), .y_ofs1(y_ofs1), .y_ofs2(y_ofs2),
    .layer_addr0(layer_addr0), .layer_addr1(layer_addr1), .layer_addr2(layer_addr2),
    .bus(bus_if), .index_latch(index_latch), .layer_load(layer_load),
    .rowscroll0(rowscroll0), .rowscroll1(rowscroll1), .rowscroll2(rowscroll2),
    .rs_active(rs_active), .cpu_state_dbg(cpu_state_dbg)
  );

  // Read-only VRAM model: data for the presented address
  logic [15:0] mem [0:32767];
  assign bus_if.vram_din = mem[bus_if.vram_addr];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];     // expected cpu_rdata per accepted access
  logic [30:0] wr_q[$];      // expected {addr, data} per accepted write
  bit prev_busy, prev_rs;
  int rs_cnt, n_done;
  bit seen_7c09;

  // ---------------- behavioural model ----------------
  // Slot position, line arming, burst position (-1 = none), CPU phase
  int  m_slot, m_rs_pos, m_cpu;   // m_cpu: 0 idle, 1 waiting, 2 accessing
  bit  m_pend, m_wr;
  logic [14:0] e_addr;
  logic [15:0] e_dout, e_idx, e_rdata;
  logic        e_we;
  logic [2:0]  e_load;
  logic [9:0]  e_rs [3];

  // Inputs as seen at the edge being modelled
  bit          s_ce, s_hp, s_req, s_we;
  logic [14:0] s_addr;
  logic [15:0] s_wdata;
  logic [9:0]  s_vcnt;
  logic [9:0]  s_yofs [3];
  logic [14:0] s_laddr [3];

  task automatic model_reset();
    m_slot = 0; m_rs_pos = -1; m_cpu = 0; m_pend = 0; m_wr = 0;
    e_addr = '0; e_dout = '0; e_idx = '0; e_rdata = '0; e_we = 0; e_load = '0;
    for (int i = 0; i < 3; i++) e_rs[i] = '0;
  endtask

  task automatic model_edge();
    int old_cpu = m_cpu;
    logic [14:0] a0 = e_addr;
    logic [15:0] din = mem[e_addr];
    int k, off, p;
    e_we = 1'b0;
    if (old_cpu == 0 && s_req) begin
      m_cpu = 1;
      m_wr  = s_we;
      exp_q.push_back(mem[s_addr]);
      if (s_we) wr_q.push_back({s_addr, s_wdata});
    end
    if (s_ce) begin
      e_load = 3'b000;
      if (m_rs_pos >= 0) begin
        p = m_rs_pos;
        if (p == 0) e_addr = 15'(RS_BASE);
        else if (p % 4 == 0) begin
          k = p / 4 - 1;
          off = (int'(s_yofs[k]) + int'(s_vcnt)) % 512;
          e_addr = 15'(RS_BASE + 'h200 * (k + 1) + off);
        end
        if (p == 7)  e_rs[0] = din[9:0];
        if (p == 10) e_rs[1] = din[9:0];
        if (p == 14) e_rs[2] = din[9:0];
        m_rs_pos = (p == 15) ? -1 : p + 1;
      end else begin
        if (m_slot < 6) begin
          k = m_slot / 2;
          if (m_slot % 2 == 0) e_addr = s_laddr[k];
          else begin
            e_addr = a0 | 15'd1;
            e_idx  = din;
            e_load = 3'(1 << k);
          end
        end else if (m_slot == 6 && old_cpu == 1) begin
          e_addr = s_addr;
          e_dout = s_wdata;
          e_we   = m_wr;
          m_cpu  = 2;
        end
        if (m_slot == 7 && m_pend) begin
          m_pend = 0;
          m_rs_pos = 0;
        end
      end
      if (m_slot == 7 && old_cpu == 2) begin
        e_rdata = din;
        m_cpu = 0;
      end
      if (s_hp) begin
        m_slot = 0;
        m_pend = 1;
      end else m_slot = (m_slot + 1) % 8;
    end
  endtask

  task automatic compare_all();
    logic [30:0] wexp;
    check("vram_addr", 64'(bus_if.vram_addr), 64'(e_addr));
    check("vram_we", 64'(bus_if.vram_we), 64'(e_we));
    check("vram_dout", 64'(bus_if.vram_dout), 64'(e_dout));
    check("cpu_busy", 64'(bus_if.cpu_busy), 64'(m_cpu != 0));
    check("cpu_rdata", 64'(bus_if.cpu_rdata), 64'(e_rdata));
    check("index_latch", 64'(index_latch), 64'(e_idx));
    check("layer_load", 64'(layer_load), 64'(e_load));
    check("rs_active", 64'(rs_active), 64'(m_rs_pos >= 0));
    check("rowscroll0", 64'(rowscroll0), 64'(e_rs[0]));
    check("rowscroll1", 64'(rowscroll1), 64'(e_rs[1]));
    check("rowscroll2", 64'(rowscroll2), 64'(e_rs[2]));
    check("rs_no_load", 64'(layer_load & {3{rs_active}}), 64'd0);
    if (rs_active && bus_if.vram_addr == 15'h7C09) seen_7c09 = 1'b1;
    // Write transactions as seen on the VRAM port
    if (bus_if.vram_we) begin
      if (wr_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
      else begin
        wexp = wr_q.pop_front();
        check("wr_txn", 64'({bus_if.vram_addr, bus_if.vram_dout}), 64'(wexp));
      end
    end
    // Completed CPU accesses
    if (prev_busy && !bus_if.cpu_busy) begin
      n_done++;
      if (exp_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
      else check("rd_txn", 64'(bus_if.cpu_rdata), 64'(exp_q.pop_front()));
    end
    prev_busy = bus_if.cpu_busy;
    // Rowscroll burst length in ce periods
    if (s_ce && prev_rs) rs_cnt++;
    if (prev_rs && !rs_active) begin
      check("rs_len", 64'(rs_cnt), 64'd16);
      rs_cnt = 0;
    end
    prev_rs = rs_active;
  endtask

  // ---------------- driver ----------------
  bit ce_rand = 0;

  task automatic tick();
    ce = ce_rand ? ($urandom_range(0, 99) < 70) : 1'b1;
    s_ce = ce; s_hp = hpulse; s_req = bus_if.cpu_req; s_we = bus_if.cpu_we;
    s_addr = bus_if.cpu_addr; s_wdata = bus_if.cpu_wdata; s_vcnt = vcnt;
    s_yofs[0] = y_ofs0; s_yofs[1] = y_ofs1; s_yofs[2] = y_ofs2;
    s_laddr[0] = layer_addr0; s_laddr[1] = layer_addr1; s_laddr[2] = layer_addr2;
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
    @(negedge clk);
    hpulse = 1'b0;
    bus_if.cpu_req = 1'b0;
  endtask

  task automatic cpu_issue(input bit we, input logic [14:0] a, input logic [15:0] d);
    bus_if.cpu_we = we; bus_if.cpu_addr = a; bus_if.cpu_wdata = d;
    bus_if.cpu_req = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bus"}, 64'({bus_if.vram_addr, bus_if.vram_dout, bus_if.vram_we,
                               bus_if.cpu_rdata, bus_if.cpu_busy}), 64'd0);
    check({tag, "_lay"}, 64'({index_latch, layer_load, rowscroll0, rowscroll1,
                               rowscroll2, rs_active}), 64'd0);
  endtask

  task automatic pulse_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    check_outputs_zero(tag);
    model_reset();
    exp_q.delete(); wr_q.delete();
    prev_busy = 0; prev_rs = 0; rs_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic tick_until_slot(input int s);
    int n = 0;
    while (m_slot != s && n < 32) begin tick(); n++; end
    check("slot_wait", 64'(m_slot), 64'(s));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, d0;
    reset_n = 1'b0; ce = 1'b0; hpulse = 1'b0;
    vcnt = '0; y_ofs0 = '0; y_ofs1 = '0; y_ofs2 = '0;
    layer_addr0 = 15'h0120; layer_addr1 = 15'h0300; layer_addr2 = 15'h0456;
    bus_if.cpu_req = 1'b0; bus_if.cpu_we = 1'b0;
    bus_if.cpu_addr = '0; bus_if.cpu_wdata = '0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem['h0120] = 16'hABCD;
    mem['h7C09] = 16'h01C5;
    mem['h0040] = 16'h00FF;
    model_reset();
    prev_busy = 0; prev_rs = 0; rs_cnt = 0; n_done = 0; seen_7c09 = 0;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;

    // Layer 0 fetch: index latched from the attribute address
    n = 0;
    while (layer_load != 3'b001 && n < 20) begin tick(); n++; end
    check("l0_load", 64'(layer_load), 64'h1);
    check("l0_idx", 64'(index_latch), 64'hABCD);
    check("l0_addr", 64'(bus_if.vram_addr), 64'h0121);
    tick();
    check("l0_load_clr", 64'(layer_load), 64'h0);
    repeat (12) tick();

    // CPU write issued at slot 2
    tick_until_slot(2);
    cpu_issue(1'b1, 15'h1234, 16'h5A5A);
    repeat (12) tick();

    // CPU read with a redundant request while busy
    d0 = n_done;
    cpu_issue(1'b0, 15'h0040, 16'h0);
    repeat (3) tick();
    bus_if.cpu_req = 1'b1;
    repeat (14) tick();
    check("rd_single", 64'(n_done - d0), 64'd1);
    check("rd_value", 64'(bus_if.cpu_rdata), 64'h00FF);

    // Rowscroll fetch with table wrap on layer 1
    vcnt = 10'd10; y_ofs0 = 10'h005; y_ofs1 = 10'h3FF; y_ofs2 = 10'h1F0;
    hpulse = 1'b1;
    repeat (40) tick();
    check("rs1_wrap", 64'(rowscroll1), 64'h1C5);
    check("rs_addr_7c09", 64'(seen_7c09), 64'd1);

    // CPU request pending when the rowscroll burst starts
    hpulse = 1'b1;
    tick();
    tick_until_slot(6);
    cpu_issue(1'b1, 15'h2222, 16'($urandom));
    tick();
    check("defer_rs", 64'(rs_active), 64'd0);
    tick();
    check("defer_rs_on", 64'(rs_active), 64'd1);
    repeat (30) tick();
    check("defer_done", 64'(wr_q.size()), 64'd0);

    // Reset while a CPU access is in its access slot
    cpu_issue(1'b1, 15'h0ABC, 16'h1357);
    n = 0;
    do begin tick(); n++; end while (m_cpu != 2 && n < 40);
    check("acc_reached", 64'(m_cpu), 64'd2);
    pulse_reset("rst_acc");
    repeat (12) tick();

    // Reset in the middle of a rowscroll burst
    hpulse = 1'b1;
    n = 0;
    do begin tick(); n++; end while (m_rs_pos < 5 && n < 40);
    check("rs_reached", 64'(rs_active), 64'd1);
    pulse_reset("rst_rs");
    repeat (12) tick();

    // Randomized traffic with gapped ce
    ce_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        vcnt = 10'($urandom); y_ofs0 = 10'($urandom);
        y_ofs1 = 10'($urandom); y_ofs2 = 10'($urandom);
      end
      if (i % 23 == 0) begin
        layer_addr0 = 15'($urandom); layer_addr1 = 15'($urandom);
        layer_addr2 = 15'($urandom);
      end
      if ($urandom_range(0, 149) == 0) hpulse = 1'b1;
      if (m_cpu == 0 && $urandom_range(0, 9) == 0)
        cpu_issue(1'($urandom_range(0, 1)), 15'($urandom), 16'($urandom));
      else if (m_cpu != 0 && $urandom_range(0, 29) == 0)
        bus_if.cpu_req = 1'b1;
      tick();
    end

    // Drain outstanding CPU work
    n = 0;
    while ((m_cpu != 0 || bus_if.cpu_busy) && n < 200) begin tick(); n++; end
    check("drain_busy", 64'(bus_if.cpu_busy), 64'd0);
    check("drain_rd_q", 64'(exp_q.size()), 64'd0);
    check("drain_wr_q", 64'(wr_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
